// File: rtl/fifo_break_r.sv
// Circular-buffer handshake FIFO that cuts the combinational ready path (ins_ready never sees outs_ready).
// Latency: one cycle from an accepted input to outs. There is no bypass path.
// Backpressure: ins_ready = !full from registered count only, so a full FIFO stalls for one cycle even while popping.
module fifo_break_r #(
  parameter int NUM_SLOTS = 4,
  parameter int DATA_TYPE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_TYPE-1:0] ins,
  input  logic                 ins_valid,
  output logic                 ins_ready,
  output logic [DATA_TYPE-1:0] outs,
  output logic                 outs_valid,
  input  logic                 outs_ready
);

  // Pointers need at least one bit even for a single-slot buffer.
  localparam int PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = $clog2(NUM_SLOTS + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(NUM_SLOTS - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(NUM_SLOTS);

  logic [DATA_TYPE-1:0] mem_q [NUM_SLOTS];
  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 empty, full;
  logic                 push, pop;

  // Explicit wrap so depths that are not a power of two work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Handshake signals derived purely from registered state.
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == FULL_CNT);
    ins_ready  = !full;
    outs_valid = !empty;
    outs       = mem_q[head_q];
    push       = ins_valid & ins_ready;
    pop        = outs_valid & outs_ready;
  end

  // Next-state for pointers and occupancy.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = next_ptr(tail_q);
    if (pop)  head_d = next_ptr(head_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; reset drops all stored entries and any transfer this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage is not reset; it is only observed while outs_valid is high.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[tail_q] <= ins;
  end

endmodule

// File: doc/fifo_break_r.md
Name: fifo_break_r

Overview:
- Circular-buffer FIFO handshake buffer that breaks the combinational ready path.
- ins_ready depends only on internal state, never on outs_ready in the same cycle.
- Placed directly downstream of the valid/data-breaking shift-register stage, so the pair cuts all three handshake paths: data, valid and ready.
- Data enters and leaves on standard valid/ready channels. There is no bypass; minimum latency is one cycle.

Parameters:
- NUM_SLOTS, 4, storage depth; legal values are >= 1, and values that are not a power of two are legal.
- DATA_TYPE, 32, payload width in bits; legal values are >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- ins  input  DATA_TYPE  input payload.
- ins_valid  input  1  input channel valid.
- ins_ready  output  1  input channel ready; a function of registered state only.
- outs  output  DATA_TYPE  output payload, read from the head slot.
- outs_valid  output  1  output channel valid; a function of registered state only.
- outs_ready  input  1  output channel ready.

Behaviour:
- State:
  - Storage array Mem[0..NUM_SLOTS-1] of DATA_TYPE bits.
  - Head pointer, tail pointer and occupancy count, each a register.
  - Pointer width is clog2(NUM_SLOTS), minimum 1 bit.
  - Count width is clog2(NUM_SLOTS+1).
- Derived signals:
  - empty = (count == 0).
  - full = (count == NUM_SLOTS).
  - ins_ready = !full.
  - outs_valid = !empty.
  - outs = Mem[head].
- Transfers:
  - push = ins_valid & ins_ready.
  - pop = outs_valid & outs_ready.
- On push: Mem[tail] <= ins, and tail advances.
- On pop: head advances.
- Pointer wrap: a pointer advances as ptr == NUM_SLOTS-1 ? 0 : ptr+1. This wraps explicitly and never relies on natural overflow, so non-power-of-two depths are handled.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop together, or on neither.
- Reset:
  - While rst=1 at a rising edge: head=0, tail=0, count=0.
  - Resulting outputs: outs_valid=0, ins_ready=1.
  - Mem is not reset; outs is don't-care while outs_valid=0.
  - Reset mid-operation discards all stored entries, and no transfer is counted in the reset cycle.
- Boundaries:
  - Empty: outs_valid=0, and no pop can occur. A push into an empty FIFO becomes visible on outs the next cycle (latency 1).
  - Full: ins_ready=0 even when outs_ready=1 in that cycle. This stall is required for ready-path breaking. The freed slot raises ins_ready one cycle after the pop.
  - Simultaneous push and pop with 0<count<NUM_SLOTS: count is unchanged, and both pointers advance with wrap.
  - NUM_SLOTS=1: behaves as a single-slot buffer with throughput 0.5 transfers/cycle under continuous traffic (alternates full/empty).
  - NUM_SLOTS>=2: sustains 1 transfer/cycle in steady state when outs_ready stays high.
- Ordering: strict FIFO; no data loss, duplication or reordering.
- Data stability: while outs_valid=1 and outs_ready=0, outs holds a constant value.
- Combinational paths: no path from outs_ready to ins_ready, and no path from ins_valid/ins to outs_valid/outs.

Test Plan:
- Reset then idle, NUM_SLOTS=4:
  - ins_valid=0 for 5 cycles.
  - Required: outs_valid=0 and ins_ready=1 throughout.
- Fill to full, NUM_SLOTS=4:
  - Push 0xA0,0xA1,0xA2,0xA3 on consecutive cycles with outs_ready=0.
  - Required: ins_ready=0 from the cycle after the 4th push, and outs=0xA0 stable.
  - Then set outs_ready=1 with ins_valid=1 held: ins_ready stays 0 in the first pop cycle and rises the next cycle. Output order is 0xA0..0xA3.
- Streaming with wrap-around, NUM_SLOTS=3:
  - Push values 1..10 continuously with outs_ready=1.
  - Required: outs_valid first asserts 1 cycle after the first push. Outputs are 1..10 in order at 1 per cycle. Pointers wrap at index 2 to 0 with no bubble.
- Random backpressure:
  - 200 random values with random ins_valid and outs_ready.
  - Required: scoreboard matches exactly. outs is stable whenever outs_valid=1 and outs_ready=0. count never exceeds NUM_SLOTS.
- Reset mid-operation:
  - With 2 entries stored, assert rst for 1 cycle while ins_valid=1 and outs_ready=1.
  - Required: next cycle outs_valid=0 and ins_ready=1. The entries are never emitted, and the push in the reset cycle is dropped.
- NUM_SLOTS=1 continuous traffic:
  - ins_valid=1 and outs_ready=1 for 10 cycles, with values 1..10 offered.
  - Required: ins_ready toggles 1,0,1,0,…. Exactly 5 values (1..5) are emitted, in order.
